// File: rtl/imuldiv_pkg.sv
// Shared constants and request/response record types for the imuldiv
// multiplier front-end and its request FIFO.
`timescale 1ns/1ps
package imuldiv_pkg;

  localparam int IMULDIV_WIDTH = 4;
  localparam int IMULDIV_TAG_W = 3;

  typedef struct packed {
    logic [IMULDIV_WIDTH-1:0] a;
    logic [IMULDIV_WIDTH-1:0] b;
    logic [IMULDIV_TAG_W-1:0] tag;
  } mul_req_t;

  typedef struct packed {
    logic [2*IMULDIV_WIDTH-1:0] result;
    logic [IMULDIV_TAG_W-1:0]   tag;
  } mul_resp_t;

endpackage

// File: rtl/imuldiv_ReqFifo.sv
// Val/rdy request FIFO, DEPTH entries of type T (power-of-two DEPTH >= 2).
// No bypass: an entry pushed on one edge is visible at the head on the next.
`timescale 1ns/1ps
module imuldiv_ReqFifo
  import imuldiv_pkg::*;
#(
  parameter type T     = mul_req_t,
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enq_val,
  output logic enq_rdy,
  input  T     enq_msg,
  output logic deq_val,
  input  logic deq_rdy,
  output T     deq_msg
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Ready looks only at the stored count, never at a same-cycle pop.
  assign enq_rdy = (count != CW'(DEPTH));
  assign deq_val = (count != '0);
  assign deq_msg = mem[rd_ptr];
  assign push    = enq_val && enq_rdy;
  assign pop     = deq_val && deq_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= enq_msg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/imuldiv_mul_tag_frontend.sv
// Tagged request/response front-end around the iterative multiplier.
// Optional counters: define IMULDIV_MUL_TAG_FRONTEND_STATS_EN for stat_ops/stat_stall.
`timescale 1ns/1ps
module imuldiv_mul_tag_frontend
  import imuldiv_pkg::*;
#(
  parameter int WIDTH = IMULDIV_WIDTH,
  parameter int TAG_W = IMULDIV_TAG_W,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [WIDTH-1:0]   req_msg_a,
  input  logic [WIDTH-1:0]   req_msg_b,
  input  logic [TAG_W-1:0]   req_msg_tag,
  output logic               mulreq_val,
  input  logic               mulreq_rdy,
  output logic [WIDTH-1:0]   mulreq_msg_a,
  output logic [WIDTH-1:0]   mulreq_msg_b,
  input  logic               mulresp_val,
  output logic               mulresp_rdy,
  input  logic [2*WIDTH-1:0] mulresp_msg_result,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [2*WIDTH-1:0] resp_msg_result,
  output logic [TAG_W-1:0]   resp_msg_tag
`ifdef IMULDIV_MUL_TAG_FRONTEND_STATS_EN
  ,
  output logic [31:0]        stat_ops,
  output logic [31:0]        stat_stall
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t               enq_msg;
  req_t               head;
  logic               fifo_val;
  logic               fifo_pop_rdy;
  logic               issue;
  logic               capture;
  logic               resp_fire;
  logic               inflight;
  logic [TAG_W-1:0]   tag_reg;
  logic               out_valid;
  logic [2*WIDTH-1:0] out_result;
  logic [TAG_W-1:0]   out_tag;

  assign enq_msg = '{a: req_msg_a, b: req_msg_b, tag: req_msg_tag};

  imuldiv_ReqFifo #(
    .T     (req_t),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .reset   (reset),
    .enq_val (req_val),
    .enq_rdy (req_rdy),
    .enq_msg (enq_msg),
    .deq_val (fifo_val),
    .deq_rdy (fifo_pop_rdy),
    .deq_msg (head)
  );

  // Only one operation may sit in the multiplier, so the head is held back while one is in flight.
  assign mulreq_val   = fifo_val && !inflight;
  assign fifo_pop_rdy = mulreq_rdy && !inflight;
  assign mulreq_msg_a = head.a;
  assign mulreq_msg_b = head.b;
  assign issue        = mulreq_val && mulreq_rdy;

  // A result arriving with nothing in flight has no tag to pair with and is dropped.
  assign mulresp_rdy  = !out_valid || resp_rdy;
  assign capture      = mulresp_val && mulresp_rdy && inflight;
  assign resp_fire    = out_valid && resp_rdy;

  assign resp_val        = out_valid;
  assign resp_msg_result = out_result;
  assign resp_msg_tag    = out_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= 1'b0;
      tag_reg  <= '0;
    end else if (issue) begin
      inflight <= 1'b1;
      tag_reg  <= head.tag;
    end else if (capture) begin
      inflight <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (capture) begin
      out_valid  <= 1'b1;
      out_result <= mulresp_msg_result;
      out_tag    <= tag_reg;
    end else if (resp_fire) begin
      out_valid  <= 1'b0;
    end
  end

  assert property (@(posedge clk) disable iff (reset) !(mulresp_val && !inflight));

`ifdef IMULDIV_MUL_TAG_FRONTEND_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (resp_fire) begin
        stat_ops <= stat_ops + 32'd1;
      end
      if (out_valid && !resp_rdy) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imuldiv_mul_tag_frontend.sv
// Scoreboard bench for imuldiv_mul_tag_frontend with a behavioural iterative
// multiplier; define IMULDIV_MUL_TAG_FRONTEND_STATS_EN to also check the counters.
`timescale 1ns/1ps
module tb_imuldiv_mul_tag_frontend;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_val;
  logic       req_rdy;
  logic [3:0] req_msg_a;
  logic [3:0] req_msg_b;
  logic [2:0] req_msg_tag;
  logic       mulreq_val;
  logic       mulreq_rdy;
  logic [3:0] mulreq_msg_a;
  logic [3:0] mulreq_msg_b;
  logic       mulresp_val;
  logic       mulresp_rdy;
  logic [7:0] mulresp_msg_result;
  logic       resp_val;
  logic       resp_rdy;
  logic [7:0] resp_msg_result;
  logic [2:0] resp_msg_tag;
`ifdef IMULDIV_MUL_TAG_FRONTEND_STATS_EN
  logic [31:0] stat_ops;
  logic [31:0] stat_stall;
`endif

  int compareCount  = 0;
  int mismatchCount = 0;
  int acceptCount   = 0;
  int mulLatency    = 3;
  logic [10:0] expQ [$];

  imuldiv_mul_tag_frontend #(.WIDTH(4), .TAG_W(3), .DEPTH(2)) dut (
    .clk                (clk),
    .reset              (reset),
    .req_val            (req_val),
    .req_rdy            (req_rdy),
    .req_msg_a          (req_msg_a),
    .req_msg_b          (req_msg_b),
    .req_msg_tag        (req_msg_tag),
    .mulreq_val         (mulreq_val),
    .mulreq_rdy         (mulreq_rdy),
    .mulreq_msg_a       (mulreq_msg_a),
    .mulreq_msg_b       (mulreq_msg_b),
    .mulresp_val        (mulresp_val),
    .mulresp_rdy        (mulresp_rdy),
    .mulresp_msg_result (mulresp_msg_result),
    .resp_val           (resp_val),
    .resp_rdy           (resp_rdy),
    .resp_msg_result    (resp_msg_result),
    .resp_msg_tag       (resp_msg_tag)
`ifdef IMULDIV_MUL_TAG_FRONTEND_STATS_EN
    ,
    .stat_ops           (stat_ops),
    .stat_stall         (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the iterative multiplier, sharing the reset net.
  logic       mulBusy;
  int         mulCnt;
  logic [7:0] mulProd;

  function automatic logic [7:0] signedProduct(input logic [3:0] a, input logic [3:0] b);
    logic signed [7:0]  ea;
    logic signed [7:0]  eb;
    logic signed [15:0] p;
    ea = {{4{a[3]}}, a};
    eb = {{4{b[3]}}, b};
    p  = ea * eb;
    return p[7:0];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mulBusy <= 1'b0;
      mulCnt  <= 0;
      mulProd <= '0;
    end else if (!mulBusy) begin
      if (mulreq_val) begin
        mulBusy <= 1'b1;
        mulCnt  <= mulLatency;
        mulProd <= signedProduct(mulreq_msg_a, mulreq_msg_b);
      end
    end else if (mulCnt != 0) begin
      mulCnt <= mulCnt - 1;
    end else if (mulresp_rdy) begin
      mulBusy <= 1'b0;
    end
  end

  assign mulreq_rdy         = !mulBusy;
  assign mulresp_val        = mulBusy && (mulCnt == 0);
  assign mulresp_msg_result = mulProd;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one request, wait (bounded) for acceptance, and log its expected response.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic [2:0] tag, input logic [7:0] expResult);
    int waited = 0;
    req_val     = 1'b1;
    req_msg_a   = a;
    req_msg_b   = b;
    req_msg_tag = tag;
    @(negedge clk);
    while (!req_rdy && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!req_rdy) begin
      checkOutput("req_accept_timeout", 32'(waited), 32'd0);
    end else begin
      expQ.push_back({expResult, tag});
      acceptCount++;
    end
    @(posedge clk);
    #1;
    req_val = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_left", 32'(expQ.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    expQ.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response handshake pops and compares against the scoreboard.
  initial begin
    logic [10:0] exp;
    forever begin
      @(negedge clk);
      if (!reset && resp_val && resp_rdy) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_resp", {21'd0, resp_msg_result, resp_msg_tag}, 32'd0);
        end else begin
          exp = expQ.pop_front();
          checkOutput("resp_tag", 32'(resp_msg_tag), 32'(exp[2:0]));
          checkOutput("resp_result", 32'(resp_msg_result), 32'(exp[10:3]));
        end
      end
    end
  end

  initial begin
    int hi;
    reset       = 1'b1;
    req_val     = 1'b0;
    req_msg_a   = '0;
    req_msg_b   = '0;
    req_msg_tag = '0;
    resp_rdy    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_req_rdy", 32'(req_rdy), 32'd1);
    checkOutput("rst_mulreq_val", 32'(mulreq_val), 32'd0);
    checkOutput("rst_mulresp_rdy", 32'(mulresp_rdy), 32'd1);
    checkOutput("rst_resp_val", 32'(resp_val), 32'd0);
    checkOutput("rst_resp_data", {21'd0, resp_msg_result, resp_msg_tag}, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] reset mid-operation");
    applyStimulus(4'h3, 4'h5, 3'd1, 8'h0F);
    applyStimulus(4'h2, 4'h2, 3'd3, 8'h04);
    reset = 1'b1;
    expQ.delete();
    @(negedge clk);
    checkOutput("midrst_resp_val", 32'(resp_val), 32'd0);
    checkOutput("midrst_req_rdy", 32'(req_rdy), 32'd1);
    checkOutput("midrst_mulreq_val", 32'(mulreq_val), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("postrst_resp_val", 32'(resp_val), 32'd0);
    checkOutput("postrst_mulreq_val", 32'(mulreq_val), 32'd0);

    $display("[TB] single ops");
    applyStimulus(4'h3, 4'h5, 3'd2, 8'h0F);
    checkOutput("issue_next_cycle", 32'(mulreq_val), 32'd1);
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_val) hi++;
    end
    checkOutput("resp_val_cycles", 32'(hi), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(4'hE, 4'h3, 3'd5, 8'hFA);
    waitDrain();

    $display("[TB] backpressure with five requests");
    resp_rdy    = 1'b0;
    acceptCount = 0;
    fork
      begin
        applyStimulus(4'h7, 4'h7, 3'd0, 8'h31);
        applyStimulus(4'hF, 4'hF, 3'd1, 8'h01);
        applyStimulus(4'h8, 4'h8, 3'd2, 8'h40);
        applyStimulus(4'h8, 4'h7, 3'd3, 8'hC8);
        applyStimulus(4'h2, 4'h6, 3'd4, 8'h0C);
      end
      begin
        repeat (40) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_accepted", 32'(acceptCount), 32'd4);
        checkOutput("bp_req_rdy", 32'(req_rdy), 32'd0);
        checkOutput("bp_mulresp_rdy", 32'(mulresp_rdy), 32'd0);
        checkOutput("bp_mulresp_val", 32'(mulresp_val), 32'd1);
        checkOutput("bp_resp_val", 32'(resp_val), 32'd1);
        checkOutput("bp_head_tag", 32'(resp_msg_tag), 32'd0);
        @(posedge clk);
        #1;
        resp_rdy = 1'b1;
      end
    join
    waitDrain();
    checkOutput("bp_total_accepted", 32'(acceptCount), 32'd5);

    $display("[TB] pointer wrap with back-to-back traffic");
    mulLatency = 0;
    applyStimulus(4'h1, 4'h1, 3'd0, 8'h01);
    applyStimulus(4'h2, 4'h3, 3'd1, 8'h06);
    applyStimulus(4'h4, 4'h4, 3'd2, 8'h10);
    applyStimulus(4'h5, 4'hD, 3'd3, 8'hF1);
    applyStimulus(4'h6, 4'h6, 3'd4, 8'h24);
    applyStimulus(4'h7, 4'hF, 3'd5, 8'hF9);
    applyStimulus(4'h0, 4'h5, 3'd6, 8'h00);
    applyStimulus(4'hC, 4'hC, 3'd7, 8'h10);
    waitDrain();
    mulLatency = 3;

`ifdef IMULDIV_MUL_TAG_FRONTEND_STATS_EN
    $display("[TB] statistics counters");
    pulseReset();
    checkOutput("stat_ops_rst", stat_ops, 32'd0);
    checkOutput("stat_stall_rst", stat_stall, 32'd0);
    resp_rdy = 1'b0;
    applyStimulus(4'h3, 4'h3, 3'd1, 8'h09);
    hi = 0;
    @(negedge clk);
    while (!resp_val && hi < 50) begin
      @(negedge clk);
      hi++;
    end
    checkOutput("stat_resp_seen", 32'(resp_val), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    resp_rdy = 1'b1;
    waitDrain();
    applyStimulus(4'h2, 4'h5, 3'd2, 8'h0A);
    waitDrain();
    applyStimulus(4'hF, 4'h4, 3'd3, 8'hFC);
    waitDrain();
    checkOutput("stat_ops", stat_ops, 32'd3);
    checkOutput("stat_stall", stat_stall, 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
